// File: rtl/memarb_pkg.sv
// Shared types and constants for the IF/MEM memory bus arbiter: FSM encoding,
// bus access sizes, reset instruction and the saturating-increment helper.
package memarb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DATA  = 2'd1,
      ST_FETCH = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [1:0]  SIZE_B   = 2'd0;
   localparam logic [1:0]  SIZE_H   = 2'd1;
   localparam logic [1:0]  SIZE_W   = 2'd2;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;
   localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == CNT_MAX) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/mem_arbiter_stall_counter.sv
// stall_counter: saturating 32-bit event counter, one cycle from en to count.
// Exists only when MEMARB_STALL_COUNT_EN is defined; no backpressure.
`ifdef MEMARB_STALL_COUNT_EN
module stall_counter
   import memarb_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   output logic [31:0] count
);

   logic [31:0] cnt_q;
   logic [31:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en) begin
         cnt_d = sat_inc(cnt_q);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;

endmodule
`endif

// File: rtl/mem_arbiter.sv
// mem_arbiter: one shared bus per pipeline step, data access then fetch; stalls until DONE.
// Bus request held until i_busAck (any wait count); optional o_stallCount via MEMARB_STALL_COUNT_EN.
module mem_arbiter
   import memarb_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Fi_PC,
   input  logic        Fi_fetchReq,
   input  logic        Mi_memRead,
   input  logic        Mi_memWrite,
   input  logic [31:0] Mi_addr,
   input  logic [31:0] Mi_writeData,
   input  logic [1:0]  Mi_memSize,
   output logic [31:0] Fo_inst,
   output logic [31:0] Mo_readData,
   output logic        o_memStall,
   output logic        o_busReq,
   output logic        o_busWrite,
   output logic [31:0] o_busAddr,
   output logic [31:0] o_busWData,
   output logic [1:0]  o_busSize,
`ifdef MEMARB_STALL_COUNT_EN
   output logic [31:0] o_stallCount,
`endif
   input  logic        i_busAck,
   input  logic [31:0] i_busRData
);

   state_e      state_q, state_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] rdata_q, rdata_d;
   logic        ls_req;

   assign ls_req = Mi_memRead | Mi_memWrite;

   // Bus outputs depend only on state and the held pipeline inputs, never on i_busAck.
   always_comb begin
      state_d    = state_q;
      inst_d     = inst_q;
      rdata_d    = rdata_q;
      o_memStall = 1'b1;
      o_busReq   = 1'b0;
      o_busWrite = 1'b0;
      o_busAddr  = '0;
      o_busWData = '0;
      o_busSize  = '0;

      case (state_q)
         ST_IDLE: begin
            o_memStall = ls_req | Fi_fetchReq;
            if (ls_req) begin
               state_d = ST_DATA;
            end else if (Fi_fetchReq) begin
               state_d = ST_FETCH;
            end
         end
         ST_DATA: begin
            o_busReq   = 1'b1;
            o_busWrite = Mi_memWrite;
            o_busAddr  = Mi_addr;
            o_busWData = Mi_writeData;
            o_busSize  = Mi_memSize;
            if (i_busAck) begin
               if (Mi_memRead) begin
                  rdata_d = i_busRData;
               end
               state_d = Fi_fetchReq ? ST_FETCH : ST_DONE;
            end
         end
         ST_FETCH: begin
            o_busReq  = 1'b1;
            o_busAddr = Fi_PC;
            o_busSize = SIZE_W;
            if (i_busAck) begin
               inst_d  = i_busRData;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            o_memStall = 1'b0;
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         inst_q  <= NOP_INST;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         inst_q  <= inst_d;
         rdata_q <= rdata_d;
      end
   end

   assign Fo_inst     = inst_q;
   assign Mo_readData = rdata_q;

`ifdef MEMARB_STALL_COUNT_EN
   stall_counter u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (o_memStall),
      .count (o_stallCount)
   );
`endif

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences a single shared memory bus between instruction fetch (IF stage) and data access (MEM stage) of the 5-stage pipeline. Each pipeline step performs the pending data access first, then the fetch. It holds the bus request stable until acknowledged and registers the returned words. It drives a stall to the hazard unit until the step's transactions are complete.

## Interface
- No parameters.
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high reset
- Fi_PC  in  32  fetch address
- Fi_fetchReq  in  1  IF stage needs an instruction this step
- Mi_memRead, Mi_memWrite  in  1 each  MEM stage load/store (never both)
- Mi_addr  in  32  data address (ALU result)
- Mi_writeData  in  32  store data
- Mi_memSize  in  2  0=byte, 1=half, 2=word
- Fo_inst  out  32  last fetched instruction
- Mo_readData  out  32  last load data, raw (extension done downstream)
- o_memStall  out  1  freeze pipeline (to hazard unit)
- o_busReq  out  1  bus request
- o_busWrite  out  1  1=write
- o_busAddr  out  32  bus address
- o_busWData  out  32  bus write data
- o_busSize  out  2  bus access size
- i_busAck  in  1  bus completes the current transaction this cycle
- i_busRData  in  32  read data, valid with i_busAck

## Operation
- FSM states: IDLE, DATA, FETCH, DONE.
  - IDLE:
    - load/store → DATA
    - else Fi_fetchReq → FETCH
    - else stay
  - DATA:
    - o_busReq=1, o_busWrite=Mi_memWrite, o_busAddr=Mi_addr, o_busWData=Mi_writeData, o_busSize=Mi_memSize.
    - On i_busAck:
      - read captures i_busRData into Mo_readData.
      - Then → FETCH if Fi_fetchReq, else → DONE.
  - FETCH:
    - o_busReq=1, o_busWrite=0, o_busAddr=Fi_PC, o_busSize=2.
    - On i_busAck: capture i_busRData into Fo_inst, → DONE.
  - DONE: o_busReq=0, → IDLE unconditionally.
- o_memStall:
  - 0 in DONE.
  - 0 in IDLE when no load/store and no Fi_fetchReq.
  - 1 otherwise.
- The pipeline advances only on a cycle with o_memStall=0.
- Upstream inputs are held stable while o_memStall=1. The block does not re-sample request changes mid-transaction.
- Bus outputs are functions of state and inputs only. In IDLE/DONE all bus outputs are 0.
- Stores never modify Mo_readData.

## Timing
- Reset (async, immediate):
  - state=IDLE, o_busReq=0
  - Fo_inst=32'h0000_0013 (nop), Mo_readData=0
- With a zero-wait bus (ack in the first request cycle):
  - fetch-only step = 3 cycles (IDLE, FETCH, DONE)
  - load/store+fetch step = 4 cycles
  - idle step = 1 cycle
- Each wait cycle of the bus (ack low) adds one cycle in DATA or FETCH.
- Fo_inst/Mo_readData update on the edge where i_busAck=1. They are valid from the following cycle through DONE and hold until the next capture.
- i_busAck in IDLE or DONE is ignored.
- Reset asserted mid-DATA/FETCH drops o_busReq asynchronously and abandons the transaction. Captured registers return to their reset values.

## Configuration
- MEMARB_STALL_COUNT_EN defined:
  - Adds output o_stallCount (32 bits).
  - Increments on every cycle with o_memStall=1.
  - Saturates at 32'hFFFF_FFFF.
  - Reset to 0.
- MEMARB_STALL_COUNT_EN undefined: port and counter are absent; all other behaviour is identical.

## Structure
- Shared package memarb_pkg holds:
  - state encoding (IDLE=0, DATA=1, FETCH=2, DONE=3)
  - size constants (SIZE_B/H/W)
  - NOP constant 32'h13
- Sub-module stall_counter (saturating 32-bit counter with enable) is instantiated only under MEMARB_STALL_COUNT_EN.
- All other logic is in one module.

## Test plan
- Reset mid-FETCH (busReq=1, no ack) → o_busReq=0 immediately, Fo_inst=32'h13, state IDLE; next Fi_fetchReq restarts from IDLE.
- Fetch-only, zero-wait: Fi_PC=32'h1_0000, ack with rdata 32'h0050_0093 in first FETCH cycle → o_memStall 1,1,0 over 3 cycles; Fo_inst=32'h0050_0093 in DONE.
- Load+fetch:
  - Stimulus: Mi_memRead=1, Mi_addr=32'h2000, size=2; bus acks data with 32'hDEAD_BEEF after 2 wait cycles, then acks fetch.
  - Response: DATA busAddr=32'h2000 held 3 cycles, then FETCH busAddr=Fi_PC; Mo_readData=32'hDEAD_BEEF; step length 6.
- Store byte: Mi_memWrite=1, Mi_addr=32'h2003, Mi_writeData=32'hAB, size=0 → o_busWrite=1, o_busSize=0, o_busWData=32'hAB; Mo_readData unchanged.
- No request (Fi_fetchReq=0, no load/store) → o_memStall=0, o_busReq=0 every cycle; a stray i_busAck changes nothing.
- With MEMARB_STALL_COUNT_EN: three fetch-only zero-wait steps → o_stallCount=6; force counter to 32'hFFFF_FFFE, two stall cycles → stays 32'hFFFF_FFFF.
